// File: rtl/multicycle_ctrl.sv
// Multi-cycle LEGv8 control FSM: fetch/decode/execute/memory/writeback sequencing with dmem timeout.
// Optional perf counters (cycle_cnt, instr_cnt) when MCTRL_PERF_EN is defined.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [10:0]          opcode,
  input  logic                 alu_zero,
  input  logic                 imem_ready,
  input  logic                 dmem_ready,
  output logic                 busy,
  output logic                 imem_req,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic [1:0]           pc_src,
  output logic                 reg2_loc,
  output logic                 alu_src,
  output logic [3:0]           alu_op,
  output logic                 dmem_read,
  output logic                 dmem_write,
  output logic                 reg_write,
  output logic                 mem_to_reg,
  output logic                 instr_done,
  output logic                 illegal,
  output logic                 mem_err,
`ifdef MCTRL_PERF_EN
  output logic [CNT_WIDTH-1:0] cycle_cnt,
  output logic [CNT_WIDTH-1:0] instr_cnt,
`endif
  output logic [2:0]           fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_ADD, C_SUB, C_AND, C_ORR, C_LDUR, C_STUR, C_CBZ, C_B, C_ILL
  } op_class_t;

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_t            state, state_n;
  logic [10:0]       op_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic              illegal_q, mem_err_q;
  logic              set_ill, set_merr, wait_inc;
  op_class_t         cls_q;

  function automatic op_class_t classify(input logic [10:0] op);
    if (op == 11'h7C2)           return C_LDUR;
    else if (op == 11'h7C0)      return C_STUR;
    else if (op == 11'h458)      return C_ADD;
    else if (op == 11'h658)      return C_SUB;
    else if (op == 11'h450)      return C_AND;
    else if (op == 11'h550)      return C_ORR;
    else if (op[10:3] == 8'hB4)  return C_CBZ;
    else if (op[10:5] == 6'h05)  return C_B;
    else                         return C_ILL;
  endfunction

  assign cls_q     = classify(op_q);
  assign illegal   = illegal_q;
  assign mem_err   = mem_err_q;
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      op_q      <= '0;
      wait_cnt  <= '0;
      illegal_q <= 1'b0;
      mem_err_q <= 1'b0;
    end else begin
      state <= state_n;
      if (state == S_DECODE) op_q <= opcode;
      wait_cnt <= wait_inc ? wait_cnt + 1'b1 : '0;
      if (set_ill)  illegal_q <= 1'b1;
      if (set_merr) mem_err_q <= 1'b1;
    end
  end

  always_comb begin
    state_n    = state;
    busy       = 1'b0;
    imem_req   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    reg2_loc   = 1'b0;
    alu_src    = 1'b0;
    alu_op     = 4'b0000;
    dmem_read  = 1'b0;
    dmem_write = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    instr_done = 1'b0;
    set_ill    = 1'b0;
    set_merr   = 1'b0;
    wait_inc   = 1'b0;
    case (state)
      S_IDLE: if (start) state_n = S_FETCH;
      S_FETCH: begin
        busy     = 1'b1;
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_n  = S_DECODE;
        end
      end
      S_DECODE: begin
        busy = 1'b1;
        if (classify(opcode) == C_ILL) begin
          set_ill = 1'b1;
          state_n = S_HALT;
        end else begin
          state_n = S_EXEC;
        end
      end
      S_EXEC: begin
        busy = 1'b1;
        case (cls_q)
          C_ADD:  begin alu_op = 4'b0010; state_n = S_WB; end
          C_SUB:  begin alu_op = 4'b0110; state_n = S_WB; end
          C_AND:  begin alu_op = 4'b0000; state_n = S_WB; end
          C_ORR:  begin alu_op = 4'b0001; state_n = S_WB; end
          C_LDUR: begin alu_op = 4'b0010; alu_src = 1'b1; state_n = S_MEM; end
          C_STUR: begin
            alu_op = 4'b0010; alu_src = 1'b1; reg2_loc = 1'b1; state_n = S_MEM;
          end
          C_CBZ: begin
            alu_op = 4'b0111; reg2_loc = 1'b1;
            pc_write = alu_zero; pc_src = 2'b01; instr_done = 1'b1; state_n = S_FETCH;
          end
          C_B: begin
            pc_write = 1'b1; pc_src = 2'b10; instr_done = 1'b1; state_n = S_FETCH;
          end
          default: state_n = S_HALT;
        endcase
      end
      S_MEM: begin
        busy       = 1'b1;
        alu_src    = 1'b1;
        alu_op     = 4'b0010;
        reg2_loc   = (cls_q == C_STUR);
        dmem_read  = (cls_q == C_LDUR);
        dmem_write = (cls_q == C_STUR);
        // ready in the final allowed cycle still completes the access
        if (dmem_ready) begin
          if (cls_q == C_LDUR) begin
            state_n = S_WB;
          end else begin
            instr_done = 1'b1;
            state_n    = S_FETCH;
          end
        end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
          set_merr = 1'b1;
          state_n  = S_HALT;
        end else begin
          wait_inc = 1'b1;
        end
      end
      S_WB: begin
        busy       = 1'b1;
        reg_write  = 1'b1;
        mem_to_reg = (cls_q == C_LDUR);
        instr_done = 1'b1;
        state_n    = S_FETCH;
      end
      S_HALT:  state_n = S_HALT;
      default: state_n = S_IDLE;
    endcase
  end

`ifdef MCTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      if (busy)       cycle_cnt <= cycle_cnt + 1'b1;
      if (instr_done) instr_cnt <= instr_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction retire records checked against a reference model via a scoreboard.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, alu_zero, imem_ready, dmem_ready;
  logic [10:0] opcode;
  logic        busy, imem_req, ir_write, pc_write, reg2_loc, alu_src;
  logic [1:0]  pc_src;
  logic [3:0]  alu_op;
  logic        dmem_read, dmem_write, reg_write, mem_to_reg, instr_done, illegal, mem_err;
  logic [2:0]  fsm_state;
`ifdef MCTRL_PERF_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif

  multicycle_ctrl #(.MEM_TIMEOUT(15), .CNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .alu_zero(alu_zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .busy(busy), .imem_req(imem_req),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .reg2_loc(reg2_loc),
    .alu_src(alu_src), .alu_op(alu_op), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .instr_done(instr_done),
    .illegal(illegal), .mem_err(mem_err),
`ifdef MCTRL_PERF_EN
    .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt),
`endif
    .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got=running req=finished");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_errors = 0;
  int n_retired = 0;
  logic [25:0] exp_q[$];

  logic [18:0] outs;
  assign outs = {busy, imem_req, ir_write, pc_write, pc_src, reg2_loc, alu_src, alu_op,
                 dmem_read, dmem_write, reg_write, mem_to_reg, instr_done, illegal, mem_err};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h req=%h", tag, got, exp);
    end
  endtask

  // record: lat, alu_op@EXEC, reg_write count, mem_to_reg, pc_write count, pc_src@retire,
  //         dmem request cycles, reg2_loc@EXEC, alu_src@EXEC, illegal, mem_err
  function automatic logic [25:0] pack_rec(input logic [5:0] lat, input logic [3:0] alu,
      input logic [1:0] rw, input logic m2r, input logic [1:0] pcw, input logic [1:0] src,
      input logic [4:0] dm, input logic r2, input logic asrc, input logic ill, input logic merr);
    return {lat, alu, rw, m2r, pcw, src, dm, r2, asrc, ill, merr};
  endfunction

  // reference model of one instruction starting in FETCH
  function automatic logic [25:0] model(input logic [10:0] op, input logic zero,
                                        input int iw, input int dw);
    int lat = iw;
    if (op == 11'h458) return pack_rec(6'(lat+4), 4'b0010, 2'd1, 0, 2'd1, 2'b00, 0, 0, 0, 0, 0);
    if (op == 11'h658) return pack_rec(6'(lat+4), 4'b0110, 2'd1, 0, 2'd1, 2'b00, 0, 0, 0, 0, 0);
    if (op == 11'h450) return pack_rec(6'(lat+4), 4'b0000, 2'd1, 0, 2'd1, 2'b00, 0, 0, 0, 0, 0);
    if (op == 11'h550) return pack_rec(6'(lat+4), 4'b0001, 2'd1, 0, 2'd1, 2'b00, 0, 0, 0, 0, 0);
    if (op == 11'h7C2 || op == 11'h7C0) begin
      logic ld = (op == 11'h7C2);
      if (dw > 15)
        return pack_rec(6'(lat+3+16), 4'b0010, 2'd0, 0, 2'd1, 2'b00, 5'd16, !ld, 1, 0, 1);
      if (ld)
        return pack_rec(6'(lat+5+dw), 4'b0010, 2'd1, 1, 2'd1, 2'b00, 5'(dw+1), 0, 1, 0, 0);
      return pack_rec(6'(lat+4+dw), 4'b0010, 2'd0, 0, 2'd1, 2'b00, 5'(dw+1), 1, 1, 0, 0);
    end
    if (op[10:3] == 8'hB4)
      return pack_rec(6'(lat+3), 4'b0111, 2'd0, 0, 2'(1+zero), 2'b01, 0, 1, 0, 0, 0);
    if (op[10:5] == 6'h05)
      return pack_rec(6'(lat+3), 4'b0000, 2'd0, 0, 2'd2, 2'b10, 0, 0, 0, 0, 0);
    return pack_rec(6'(lat+2), 4'b0000, 2'd0, 0, 2'd1, 2'b00, 0, 0, 0, 1, 0);
  endfunction

  // driver: called at a negedge with the FSM in FETCH; runs until retire or halt
  task automatic run_instr(input string tag, input logic [10:0] op, input logic zero,
                           input int iw, input int dw);
    int cyc = 0, dm = 0;
    logic [5:0] lat = 0;
    logic [3:0] alu = 0;
    logic [1:0] rw = 0, pcw = 0, src = 0;
    logic m2r = 0, r2 = 0, asrc = 0, fin = 0;
    logic [25:0] exp;
    exp_q.push_back(model(op, zero, iw, dw));
    opcode = op;
    alu_zero = zero;
    while (!fin && cyc < 60) begin
      imem_ready = (cyc >= iw);
      dmem_ready = (dm == dw);
      #1;
      if (!busy) begin
        lat = 6'(cyc);
        fin = 1'b1;
      end else begin
        if (cyc == iw + 2) begin alu = alu_op; r2 = reg2_loc; asrc = alu_src; end
        if (dmem_read || dmem_write) dm++;
        if (reg_write) begin rw++; m2r = mem_to_reg; end
        if (pc_write) pcw++;
        if (instr_done) begin
          src = pc_src; lat = 6'(cyc + 1); fin = 1'b1; n_retired++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    exp = exp_q.pop_front();
    check(tag, {6'd0, lat, alu, rw, m2r, pcw, src, 5'(dm), r2, asrc, illegal, mem_err}, {6'd0, exp});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  function automatic logic [10:0] rand_op();
    case ($urandom_range(0, 7))
      0: return 11'h458;
      1: return 11'h658;
      2: return 11'h450;
      3: return 11'h550;
      4: return 11'h7C2;
      5: return 11'h7C0;
      6: return {8'hB4, 3'($urandom_range(0, 7))};
      default: return {6'h05, 5'($urandom_range(0, 31))};
    endcase
  endfunction

  initial begin
    opcode = '0; alu_zero = 0; imem_ready = 0; dmem_ready = 0;
    @(negedge clk);
    do_reset();
    #1 check("reset_outs", 32'(outs), 32'd0);
    @(negedge clk);

    pulse_start();
    run_instr("add",       11'h458, 0, 0, 0);
    run_instr("sub",       11'h658, 0, 0, 0);
    run_instr("and",       11'h450, 0, 1, 0);
    run_instr("orr",       11'h550, 0, 0, 0);
    run_instr("ldur_w3",   11'h7C2, 0, 0, 3);
    run_instr("stur_w0",   11'h7C0, 0, 0, 0);
    run_instr("cbz_taken", 11'h5A0, 1, 0, 0);
    run_instr("cbz_not",   11'h5A7, 0, 0, 0);
    run_instr("b",         11'h0BF, 0, 0, 0);
    run_instr("ldur_iw2",  11'h7C2, 0, 2, 1);
    run_instr("stur_w15",  11'h7C0, 0, 0, 15);
    for (int i = 0; i < 24; i++)
      run_instr("rand", rand_op(), 1'($urandom_range(0, 1)), $urandom_range(0, 2),
                $urandom_range(0, 5));
`ifdef MCTRL_PERF_EN
    check("instr_cnt", instr_cnt, 32'(n_retired));
`endif

    run_instr("illegal", 11'h000, 0, 0, 0);
    pulse_start();
    #1 check("halt_ill_hold", 32'(outs), 32'h2);
    @(negedge clk);
    do_reset();
    #1 check("reset_clr_ill", 32'(outs), 32'd0);
    @(negedge clk);

    pulse_start();
    run_instr("stur_tmo", 11'h7C0, 0, 0, 99);
    pulse_start();
    #1 check("halt_merr_hold", 32'(outs), 32'h1);
    @(negedge clk);
    do_reset();

    pulse_start();
    opcode = 11'h7C0;
    imem_ready = 1'b1;
    dmem_ready = 1'b0;
    repeat (5) @(negedge clk);
    #1 check("mid_mem_req", 32'(dmem_write), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    #1 check("mid_mem_reset", 32'(outs), 32'd0);
`ifdef MCTRL_PERF_EN
    check("perf_reset", {cycle_cnt[15:0], instr_cnt[15:0]}, 32'd0);
`endif
    reset = 1'b0;
    imem_ready = 1'b0;
    @(negedge clk);
    #1 check("idle_after_reset", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
